// File: rtl/johnson_pkg.sv
// Shared types and the Johnson code legality / phase decode helper.
package johnson_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK  = 2'd1,
      FAULT = 2'd2
   } state_e;

   // Widest code the decode helper accepts, and the default code width.
   localparam int unsigned MAX_N       = 32;
   localparam int unsigned DEF_N       = 8;
   localparam int unsigned DEF_PHASE_W = $clog2(2 * DEF_N);
   localparam int unsigned DEC_PHASE_W = 8;

   typedef struct packed {
      logic                   legal;
      logic [DEC_PHASE_W-1:0] phase;
   } jdec_t;

   // Decode an n-bit Johnson code (zero-extended into MAX_N bits).
   // Lower half of the ring is a run of ones from bit 0; upper half is the
   // complement, so both halves reduce to the same "low run of ones" test.
   function automatic jdec_t johnson_decode(input logic [MAX_N-1:0] code,
                                            input int unsigned       n);
      logic [MAX_N-1:0] mask;
      logic [MAX_N-1:0] v;
      logic             msb;
      jdec_t            d;
      mask    = (n >= MAX_N) ? '1 : ((MAX_N'(1) << n) - MAX_N'(1));
      msb     = |(code & (MAX_N'(1) << (n - 1)));
      v       = msb ? (~code & mask) : (code & mask);
      d.legal = ((v & (v + MAX_N'(1))) == '0);
      d.phase = msb ? (DEC_PHASE_W'(n) + DEC_PHASE_W'($countones(v)))
                    : DEC_PHASE_W'($countones(v));
      return d;
   endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational Johnson code checker: code -> {legal, phase}.
module johnson_code_check
   import johnson_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0]             code,
   output logic                     legal_c,
   output logic [$clog2(2*N)-1:0]   phase_c
);

   localparam int unsigned PHASE_W = $clog2(2 * N);

   jdec_t dec_c;

   // Reuse the package decoder at this instance's width.
   always_comb begin
      dec_c   = johnson_decode(MAX_N'(code), N);
      legal_c = dec_c.legal;
      phase_c = PHASE_W'(dec_c.phase);
   end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Johnson ring consumer: decodes phase, counts revolutions, tracks lock.
module johnson_phase_decoder
   import johnson_pkg::*;
#(
   parameter int unsigned N      = 8,
   parameter int unsigned REV_W  = 8,
   parameter int unsigned RELOCK = 4
) (
   input  logic                    CLK,
   input  logic                    RESETN,
   input  logic [N-1:0]            I,
   input  logic                    CLR_ERR,
   output logic [$clog2(2*N)-1:0]  PHASE,
   output logic [2*N-1:0]          ONEHOT,
   output logic                    VALID,
   output logic                    WRAP,
   output logic [REV_W-1:0]        REVS,
   output logic                    ERR
);

   localparam int unsigned PHASE_W    = $clog2(2 * N);
   localparam int unsigned LAST_PHASE = 2 * N - 1;
   localparam int unsigned REL_W      = $clog2(RELOCK + 1);

   logic [N-1:0]       r_i;
   logic               legal_c;
   logic [PHASE_W-1:0] phase_c;

   state_e             state_q, state_n;
   logic [PHASE_W-1:0] prev_q, prev_n;
   logic [REL_W-1:0]   rel_q, rel_n;
   logic [PHASE_W-1:0] phase_n;
   logic [2*N-1:0]     onehot_n;
   logic               valid_n, wrap_n, err_n, err_set;
   logic [REV_W-1:0]   revs_n;
   logic [PHASE_W-1:0] next_prev_c;
   logic               step_c, hold_c;

   // Input capture stage.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) r_i <= '0;
      else         r_i <= I;
   end

   johnson_code_check #(.N(N)) u_check (
      .code    (r_i),
      .legal_c (legal_c),
      .phase_c (phase_c)
   );

   // Step / hold classification relative to the last legal phase.
   always_comb begin
      next_prev_c = (prev_q == PHASE_W'(LAST_PHASE)) ? '0 : prev_q + PHASE_W'(1);
      step_c      = legal_c && (phase_c == next_prev_c);
      hold_c      = legal_c && (phase_c == prev_q);
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n  = state_q;
      prev_n   = legal_c ? phase_c : prev_q;
      rel_n    = rel_q;
      phase_n  = legal_c ? phase_c : PHASE;
      valid_n  = VALID;
      wrap_n   = 1'b0;
      revs_n   = REVS;
      err_set  = 1'b0;
      onehot_n = '0;

      unique case (state_q)
         IDLE: begin
            if (legal_c) begin
               state_n = LOCK;
               valid_n = 1'b1;
            end else begin
               err_set = 1'b1;
            end
         end
         LOCK: begin
            if (step_c || hold_c) begin
               valid_n = 1'b1;
               if (step_c && (phase_c == '0)) begin
                  wrap_n = 1'b1;
                  revs_n = REVS + REV_W'(1);
               end
            end else begin
               state_n = FAULT;
               valid_n = 1'b0;
               err_set = 1'b1;
               rel_n   = '0;
            end
         end
         FAULT: begin
            if (step_c) begin
               if ((rel_q + REL_W'(1)) == REL_W'(RELOCK)) begin
                  state_n = LOCK;
                  valid_n = 1'b1;
                  rel_n   = '0;
               end else begin
                  rel_n = rel_q + REL_W'(1);
               end
            end else if (hold_c) begin
               rel_n = rel_q;
            end else if (legal_c) begin
               rel_n = '0;
            end else begin
               rel_n   = '0;
               err_set = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            valid_n = 1'b0;
         end
      endcase

      if (valid_n) onehot_n[phase_n] = 1'b1;

      // Set wins over clear.
      if (err_set)      err_n = 1'b1;
      else if (CLR_ERR) err_n = 1'b0;
      else              err_n = ERR;
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= IDLE;
         prev_q  <= '0;
         rel_q   <= '0;
         PHASE   <= '0;
         ONEHOT  <= '0;
         VALID   <= 1'b0;
         WRAP    <= 1'b0;
         REVS    <= '0;
         ERR     <= 1'b0;
      end else begin
         state_q <= state_n;
         prev_q  <= prev_n;
         rel_q   <= rel_n;
         PHASE   <= phase_n;
         ONEHOT  <= onehot_n;
         VALID   <= valid_n;
         WRAP    <= wrap_n;
         REVS    <= revs_n;
         ERR     <= err_n;
      end
   end

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Randomized bench for johnson_phase_decoder against a table-driven model.
module tb_johnson_phase_decoder;

   localparam int N      = 8;
   localparam int P      = 2 * N;
   localparam int REV_W  = 8;
   localparam int RELOCK = 4;

   localparam int M_IDLE  = 0;
   localparam int M_LOCK  = 1;
   localparam int M_FAULT = 2;

   logic              CLK;
   logic              RESETN;
   logic [N-1:0]      I;
   logic              CLR_ERR;
   logic [3:0]        PHASE;
   logic [P-1:0]      ONEHOT;
   logic              VALID;
   logic              WRAP;
   logic [REV_W-1:0]  REVS;
   logic              ERR;

   johnson_phase_decoder #(.N(N), .REV_W(REV_W), .RELOCK(RELOCK)) dut (
      .CLK     (CLK),
      .RESETN  (RESETN),
      .I       (I),
      .CLR_ERR (CLR_ERR),
      .PHASE   (PHASE),
      .ONEHOT  (ONEHOT),
      .VALID   (VALID),
      .WRAP    (WRAP),
      .REVS    (REVS),
      .ERR     (ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Legal code for each ring position, built by filling / clearing bits.
   function automatic logic [N-1:0] code_of(input int p);
      logic [N-1:0] c;
      if (p < N) begin
         c = '0;
         for (int k = 0; k < p; k++) c[k] = 1'b1;
      end else begin
         c = '1;
         for (int k = 0; k < p - N; k++) c[k] = 1'b0;
      end
      return c;
   endfunction

   // Phase by table lookup; -1 when the word is not in the ring.
   function automatic int ref_phase(input logic [N-1:0] c);
      for (int p = 0; p < P; p++) if (code_of(p) == c) return p;
      return -1;
   endfunction

   // Reference model state.
   logic [N-1:0] m_ri;
   int m_mode, m_prev, m_rel, m_phase, m_revs;
   bit m_valid, m_wrap, m_err;

   task automatic model_reset();
      m_ri = '0; m_mode = M_IDLE; m_prev = 0; m_rel = 0; m_phase = 0;
      m_revs = 0; m_valid = 0; m_wrap = 0; m_err = 0;
   endtask

   // One clock edge of the model: decode the held word, then capture I.
   task automatic model_tick();
      int ph;
      bit lg, st, hd, es;
      ph = ref_phase(m_ri);
      lg = (ph >= 0);
      st = lg && (ph == (m_prev + 1) % P);
      hd = lg && (ph == m_prev);
      es = 0;
      m_wrap = 0;
      case (m_mode)
         M_IDLE: begin
            if (lg) begin m_mode = M_LOCK; m_valid = 1; end
            else es = 1;
         end
         M_LOCK: begin
            if (st || hd) begin
               m_valid = 1;
               if (st && ph == 0) begin m_wrap = 1; m_revs = (m_revs + 1) % 256; end
            end else begin
               m_mode = M_FAULT; m_valid = 0; es = 1; m_rel = 0;
            end
         end
         default: begin
            if (st) begin
               m_rel++;
               if (m_rel == RELOCK) begin m_mode = M_LOCK; m_valid = 1; m_rel = 0; end
            end else if (!hd) begin
               m_rel = 0;
               if (!lg) es = 1;
            end
         end
      endcase
      if (lg) begin m_prev = ph; m_phase = ph; end
      if (es) m_err = 1;
      else if (CLR_ERR) m_err = 0;
      m_ri = I;
   endtask

   task automatic compare_all();
      logic [31:0] oh;
      oh = m_valid ? (32'd1 << m_phase) : 32'd0;
      check("VALID", 32'(VALID), 32'(m_valid));
      if (m_valid) check("PHASE", 32'(PHASE), 32'(m_phase));
      check("ONEHOT", 32'(ONEHOT), oh);
      check("WRAP", 32'(WRAP), 32'(m_wrap));
      check("REVS", 32'(REVS), 32'(m_revs));
      check("ERR", 32'(ERR), 32'(m_err));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_PHASE"}, 32'(PHASE), 32'd0);
      check({tag, "_ONEHOT"}, 32'(ONEHOT), 32'd0);
      check({tag, "_VALID"}, 32'(VALID), 32'd0);
      check({tag, "_WRAP"}, 32'(WRAP), 32'd0);
      check({tag, "_REVS"}, 32'(REVS), 32'd0);
      check({tag, "_ERR"}, 32'(ERR), 32'd0);
   endtask

   int cur = 0;

   task automatic drive(input logic [N-1:0] code, input logic clr);
      I = code;
      CLR_ERR = clr;
      @(posedge CLK);
      model_tick();
      #1;
      compare_all();
   endtask

   task automatic drive_ph(input int p);
      cur = p % P;
      drive(code_of(cur), 1'b0);
   endtask

   initial begin
      int r, r0;
      logic [N-1:0] c;
      I = '0; CLR_ERR = 1'b0; RESETN = 1'b0;
      model_reset();
      #12;
      check_zero("reset");
      @(negedge CLK) RESETN = 1'b1;

      // Ideal revolution 0..15,0 then a little more.
      for (int p = 0; p <= 18; p++) drive_ph(p);
      check("revs_one", 32'(REVS), 32'd1);

      // Illegal injection, then RELOCK steps.
      drive(8'h05, 1'b0);
      for (int k = 0; k < RELOCK; k++) drive_ph(cur + 1);
      drive_ph(cur + 1);
      check("relock_valid", 32'(VALID), 32'd1);
      check("relock_err", 32'(ERR), 32'd1);

      // Skip a phase 2 -> 4.
      while (cur != 2) drive_ph(cur + 1);
      drive_ph(4);
      drive_ph(5);
      check("skip_valid", 32'(VALID), 32'd0);

      // Relock, clear ERR, then hold at phase 3.
      for (int k = 0; k < 6; k++) drive_ph(cur + 1);
      while (cur != 2) drive_ph(cur + 1);
      drive(code_of(cur), 1'b1);
      for (int k = 0; k < 3; k++) drive_ph(3);
      drive_ph(4);
      drive_ph(5);
      check("hold_err", 32'(ERR), 32'd0);
      check("hold_valid", 32'(VALID), 32'd1);

      // CLR_ERR coincident with an illegal decode, then alone.
      drive(8'h05, 1'b0);
      drive(code_of(cur), 1'b1);
      check("clr_vs_set", 32'(ERR), 32'd1);
      drive(code_of(cur), 1'b1);
      check("clr_alone", 32'(ERR), 32'd0);

      // Randomized mix of steps, holds, illegal words and jumps.
      for (int k = 0; k < 600; k++) begin
         r = int'($urandom_range(0, 99));
         if (r < 75) begin
            cur = (cur + 1) % P; c = code_of(cur);
         end else if (r < 85) begin
            c = code_of(cur);
         end else if (r < 93) begin
            c = N'($urandom);
            while (ref_phase(c) >= 0) c = N'($urandom);
         end else begin
            cur = int'($urandom_range(0, P - 1)); c = code_of(cur);
         end
         drive(c, ($urandom_range(0, 9) == 0));
      end

      // 256 locked revolutions return REVS to its starting value.
      for (int k = 0; k < 8; k++) drive_ph(cur + 1);
      r0 = m_revs;
      for (int k = 0; k < 256 * P; k++) drive_ph(cur + 1);
      check("revs_wrap", 32'(REVS), 32'(r0));

      // Asynchronous reset mid-revolution.
      for (int k = 0; k < 5; k++) drive_ph(cur + 1);
      #3 RESETN = 1'b0;
      #1;
      check_zero("async_rst");
      model_reset();
      #2 RESETN = 1'b1;
      for (int p = 0; p <= 20; p++) drive_ph(p);
      check("reacq_valid", 32'(VALID), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
